// File: rtl/video_fetch_fifo.sv
// Frame-buffer prefetcher for the 640x480 mono display: fetches 32-bit words from
// main RAM into a small FIFO and serves them to the display one byte per rd pulse.
module video_fetch_fifo #(
  parameter int fifo_bits   = 4,
  parameter int frame_words = 9600,
  parameter int addr_bits   = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [addr_bits-1:0] base_addr,
  input  logic                 vsync_n,
  input  logic                 rd,
  output logic [7:0]           data_out,
  output logic [addr_bits-1:0] mem_addr,
  output logic                 mem_req,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_data,
  output logic                 underflow
);

  localparam int DEPTH = 1 << fifo_bits;
  localparam int CNT_W = $clog2(frame_words + 1);
  localparam logic [CNT_W-1:0]     FRAME_CNT = CNT_W'(frame_words);
  localparam logic [CNT_W-1:0]     WCNT_ONE  = CNT_W'(1);
  localparam logic [fifo_bits-1:0] PTR_ONE   = fifo_bits'(1);
  localparam logic [fifo_bits:0]   CNT_ONE   = (fifo_bits + 1)'(1);
  localparam logic [addr_bits-1:0] ADDR_ONE  = addr_bits'(1);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_ACK, DRAIN} state_t;

  state_t                r_state;
  logic                  r_vs_meta, r_vs_sync, r_vs_prev;
  logic [31:0]           r_mem [DEPTH];
  logic [fifo_bits-1:0]  r_wr_ptr, r_rd_ptr;
  logic [fifo_bits:0]    r_count;
  logic [1:0]            r_byte_sel;
  logic [CNT_W-1:0]      r_word_cnt;
  logic [addr_bits-1:0]  r_mem_addr, r_drain_addr;
  logic                  r_mem_req, r_underflow;
  logic [7:0]            r_data_out;

  logic                  w_frame_start, w_wr_en, w_empty, w_rd_ok, w_pop;
  logic [fifo_bits-1:0]  w_rd_ptr_next;
  logic [fifo_bits:0]    w_count_next;
  logic [1:0]            w_byte_sel_next;
  logic [31:0]           w_head_next;
  logic [7:0]            w_data_out_next;

  assign w_frame_start = r_vs_prev & ~r_vs_sync;
  assign w_wr_en       = mem_ack & r_mem_req & (r_state == WAIT_ACK) & ~w_frame_start;
  assign w_empty       = (r_count == '0);
  assign w_rd_ok       = rd & ~w_empty & ~w_frame_start;
  assign w_pop         = w_rd_ok & (r_byte_sel == 2'd3);

  always_comb begin
    w_rd_ptr_next   = w_pop ? r_rd_ptr + PTR_ONE : r_rd_ptr;
    w_count_next    = r_count;
    if (w_wr_en && !w_pop)
      w_count_next = r_count + CNT_ONE;
    else if (!w_wr_en && w_pop)
      w_count_next = r_count - CNT_ONE;
    w_byte_sel_next = r_byte_sel;
    if (w_frame_start)
      w_byte_sel_next = 2'd0;
    else if (w_rd_ok)
      w_byte_sel_next = r_byte_sel + 2'd1;
    // A write landing on the new head slot means the FIFO was (or became) empty.
    if (w_wr_en && (r_wr_ptr == w_rd_ptr_next))
      w_head_next = mem_data;
    else
      w_head_next = r_mem[w_rd_ptr_next];
    if (w_frame_start || (w_count_next == '0))
      w_data_out_next = 8'h00;
    else
      w_data_out_next = w_head_next[{w_byte_sel_next, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= mem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_vs_meta    <= 1'b1;
      r_vs_sync    <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_byte_sel   <= 2'd0;
      r_word_cnt   <= '0;
      r_mem_addr   <= '0;
      r_drain_addr <= '0;
      r_mem_req    <= 1'b0;
      r_underflow  <= 1'b0;
      r_data_out   <= 8'h00;
    end else begin
      r_vs_meta  <= vsync_n;
      r_vs_sync  <= r_vs_meta;
      r_vs_prev  <= r_vs_sync;
      r_data_out <= w_data_out_next;
      r_byte_sel <= w_byte_sel_next;
      if (w_frame_start) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_word_cnt  <= '0;
        r_underflow <= 1'b0;
        if (r_mem_req && !mem_ack) begin
          // Old request still in flight: keep its address stable, park the new base.
          r_state      <= DRAIN;
          r_drain_addr <= base_addr;
        end else begin
          r_state    <= FILL;
          r_mem_req  <= 1'b0;
          r_mem_addr <= base_addr;
        end
      end else begin
        r_rd_ptr <= w_rd_ptr_next;
        r_count  <= w_count_next;
        if (w_wr_en)
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (rd && w_empty)
          r_underflow <= 1'b1;
        case (r_state)
          IDLE: begin
          end
          FILL: begin
            if (r_word_cnt == FRAME_CNT)
              r_state <= IDLE;
            else if (!r_count[fifo_bits]) begin
              r_mem_req <= 1'b1;
              r_state   <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (mem_ack) begin
              r_mem_req  <= 1'b0;
              r_mem_addr <= r_mem_addr + ADDR_ONE;
              r_word_cnt <= r_word_cnt + WCNT_ONE;
              r_state    <= FILL;
            end
          end
          DRAIN: begin
            if (mem_ack) begin
              r_mem_req  <= 1'b0;
              r_mem_addr <= r_drain_addr;
              r_state    <= FILL;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_out  = r_data_out;
  assign mem_addr  = r_mem_addr;
  assign mem_req   = r_mem_req;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_video_fetch_fifo.sv
// Self-checking bench for video_fetch_fifo: a transaction-level model (word queue,
// byte index, expected next address) is compared with the DUT every clock.
module tb_video_fetch_fifo;

  localparam int FW = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [29:0] base_addr = 30'h100;
  logic        vsync_n = 1'b1;
  logic        rd = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic [7:0]  data_out;
  logic [29:0] mem_addr;
  logic        mem_req;
  logic        underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] q[$];
  int          bsel;
  logic        m_under;
  int          words;
  logic [29:0] nxt_addr;
  bit          drain;
  bit          vh[4];
  int          ack_delay = 2;
  int          req_age = 0;
  bit          spurious_en = 0;
  bit          first_fixed = 0;
  logic [29:0] held_addr = '0;

  video_fetch_fifo #(.fifo_bits(4), .frame_words(FW), .addr_bits(30)) dut (
    .clk(clk), .rst_n(rst_n), .base_addr(base_addr), .vsync_n(vsync_n), .rd(rd),
    .data_out(data_out), .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_data(mem_data), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte();
    logic [31:0] w;
    if (q.size() == 0) return 8'h00;
    w = q[0];
    return w[8*bsel +: 8];
  endfunction

  task automatic model_reset();
    q.delete();
    bsel = 0; m_under = 1'b0; words = 0; nxt_addr = '0; drain = 0; req_age = 0;
    for (int i = 0; i < 4; i++) vh[i] = 1'b1;
  endtask

  // One clock: drive inputs, update the model for the coming edge, then check.
  task automatic step(input bit do_rd);
    bit   fs, ack_eff, prev_req;
    int   qsize_pre, words_pre;
    rd = do_rd;
    if (mem_req) begin
      req_age++;
      mem_ack = (req_age >= ack_delay);
    end else begin
      req_age = 0;
      mem_ack = spurious_en && ($urandom_range(0, 7) == 0);
    end
    mem_data = (first_fixed && words == 0) ? 32'h44332211 : $urandom;
    vh[0] = vsync_n;
    fs = !vh[2] && vh[3];
    ack_eff = mem_ack && mem_req;
    prev_req = mem_req;
    qsize_pre = q.size();
    words_pre = words;
    if (fs) begin
      q.delete();
      bsel = 0; words = 0; m_under = 1'b0; nxt_addr = base_addr;
      drain = mem_req && !mem_ack;
    end else begin
      if (ack_eff) begin
        if (drain) drain = 0;
        else begin
          $display("xact word=%0d addr=%h data=%h", words, nxt_addr, mem_data);
          q.push_back(mem_data);
          nxt_addr = nxt_addr + 30'd1;
          words++;
        end
      end
      if (do_rd) begin
        if (qsize_pre == 0) m_under = 1'b1;
        else if (bsel == 3) begin void'(q.pop_front()); bsel = 0; end
        else bsel++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 3; i > 0; i--) vh[i] = vh[i-1];
    rd = 1'b0;
    mem_ack = 1'b0;
    chk("data_out", data_out, exp_byte());
    chk("underflow", underflow, m_under);
    if (mem_req && !prev_req) begin
      chk("req_addr", mem_addr, nxt_addr);
      chk("req_room", (qsize_pre <= 15), 1'b1);
      chk("req_frame", (words_pre < FW), 1'b1);
      held_addr = mem_addr;
    end else if (mem_req) begin
      chk("addr_hold", mem_addr, held_addr);
    end
  endtask

  initial begin
    int n;
    int next_vs;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 30'h0);
    chk("rst_underflow", underflow, 1'b0);
    rst_n = 1'b1;

    // Fill a frame from 0x100 with a 2-clk ack latency
    first_fixed = 1;
    ack_delay = 2;
    vsync_n = 1'b0;
    repeat (3) step(0);
    vsync_n = 1'b1;
    n = 0;
    while (!(q.size() == 16 && !mem_req) && n < 200) begin step(0); n++; end
    chk("t1_fill_done", (n < 200), 1'b1);
    first_fixed = 0;
    repeat (8) begin step(0); chk("t1_stall_req", mem_req, 1'b0); end

    // Byte order and refill after the fourth rd
    chk("t2_byte0", data_out, 8'h11);
    step(1); chk("t2_byte1", data_out, 8'h22);
    step(1); chk("t2_byte2", data_out, 8'h33);
    step(1); chk("t2_byte3", data_out, 8'h44);
    step(1);
    step(0); chk("t2_refill_req", mem_req, 1'b1);

    // Frame end: exactly FW words, then silence
    n = 0;
    while (!(words == FW && !mem_req) && n < 400) begin step($urandom_range(0, 2) == 0); n++; end
    chk("t3_frame_done", (n < 400), 1'b1);
    chk("t3_words", words, FW);
    repeat (100) begin step(1); chk("t3_no_req", mem_req, 1'b0); end

    // Underflow with an empty FIFO, cleared by the next frame start
    chk("t5_underflow", underflow, 1'b1);
    chk("t5_data_out", data_out, 8'h00);
    base_addr = 30'h200;
    ack_delay = 5;
    vsync_n = 1'b0;
    repeat (3) step(1);
    vsync_n = 1'b1;
    chk("t5_under_clr", underflow, 1'b0);

    // Frame start while a request is outstanding -> drain, restart at new base
    base_addr = 30'h300;
    n = 0;
    while (!mem_req && n < 10) begin step(0); n++; end
    chk("t4_req_seen", mem_req, 1'b1);
    vsync_n = 1'b0;
    repeat (3) step(0);
    vsync_n = 1'b1;
    chk("t4_in_drain", drain, 1'b1);
    n = 0;
    while ((drain || !mem_req) && n < 30) begin step(0); n++; end
    chk("t4_drain_done", (n < 30), 1'b1);
    chk("t4_new_base", mem_addr, 30'h300);
    chk("t4_discarded", data_out, 8'h00);

    // Asynchronous reset in the middle of a fill
    ack_delay = 2;
    repeat (20) step(0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_data_out", data_out, 8'h00);
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_mem_addr", mem_addr, 30'h0);
    chk("t6_underflow", underflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) begin step(0); chk("t6_no_req", mem_req, 1'b0); end

    // Randomized traffic: random rd, ack latency, spurious acks, frame restarts
    spurious_en = 1;
    next_vs = 5;
    for (int s = 0; s < 3000; s++) begin
      if (!mem_req) ack_delay = $urandom_range(1, 5);
      if (s == next_vs) begin
        base_addr = ($urandom_range(0, 1) == 1) ? 30'h3FFF_FFF6 : 30'($urandom);
        vsync_n = 1'b0;
      end
      if (s == next_vs + 2) begin
        vsync_n = 1'b1;
        next_vs = s + $urandom_range(20, 150);
      end
      step($urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
